// File: rtl/capsense_scan_ctrl.sv
// Capacitive-sense scan controller: discharges and times one pad at a time,
// calibrates a per-pad baseline and derives debounced, hysteretic touch flags.
module capsense_scan_ctrl #(
  parameter int unsigned N             = 4,
  parameter int unsigned DISCHARGE_CYC = 16,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned CAL_LOG2      = 3,
  parameter int unsigned THRESHOLD     = 8,
  localparam int unsigned PW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          recal_i,
  input  logic [N-1:0]  capsense_i,
  output logic [N-1:0]  capsense_oe_o,
  output logic [N-1:0]  buttons_o,
  output logic          valid_o,
  output logic [7:0]    count_o,
  output logic [PW-1:0] pad_o,
  output logic          cal_done_o,
  output logic          busy_o
);

  localparam int unsigned CW    = 8;
  localparam int unsigned CW1   = CW + 1;
  localparam int unsigned ACC_W = CW + CAL_LOG2;
  localparam int unsigned DW    = $clog2(DISCHARGE_CYC);
  localparam int unsigned PC_W  = CAL_LOG2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIS  = 2'd1;
  localparam logic [1:0] S_CHG  = 2'd2;
  localparam logic [1:0] S_EVAL = 2'd3;

  localparam logic [PW-1:0]   LAST_PAD   = PW'(N - 1);
  localparam logic [DW-1:0]   DIS_LAST   = DW'(DISCHARGE_CYC - 1);
  localparam logic [CW-1:0]   CNT_SAT    = CW'(TIMEOUT);
  localparam logic [PC_W-1:0] PASS_FINAL = PC_W'(1 << CAL_LOG2);

  logic [1:0]       state, state_d;
  logic [PW-1:0]    pad, pad_d;
  logic [DW-1:0]    dcnt, dcnt_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [N-1:0]     oe_d;
  logic [N-1:0]     sync1, sync2;
  logic [ACC_W-1:0] acc [N];
  logic [ACC_W-1:0] acc_upd [N];
  logic [CW-1:0]    base [N];
  logic [PC_W-1:0]  pass_cnt, pass_inc;
  logic             recal_pend, recal_now;
  logic             pass_end, calibrating, cal_finish;
  logic [CW1-1:0]   cnt_ext, hi_thr, lo_thr;

  // Next-state logic: discharge, timed charge, single-cycle evaluate
  always_comb begin
    state_d = state;
    pad_d   = pad;
    dcnt_d  = dcnt;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_DIS;
          pad_d   = '0;
          dcnt_d  = '0;
        end
      end
      S_DIS: begin
        if (dcnt == DIS_LAST) begin
          state_d = S_CHG;
          cnt_d   = '0;
        end else begin
          dcnt_d = dcnt + DW'(1);
        end
      end
      S_CHG: begin
        if (sync2[pad] || (cnt == CNT_SAT)) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_EVAL: begin
        dcnt_d = '0;
        if (!en_i) begin
          state_d = S_IDLE;
          pad_d   = '0;
        end else begin
          state_d = S_DIS;
          pad_d   = (pad == LAST_PAD) ? '0 : pad + PW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        pad_d   = '0;
      end
    endcase
  end

  // Only the selected pad is released, and only while it is being timed
  always_comb begin
    oe_d = '1;
    if ((state_d == S_CHG) || (state_d == S_EVAL)) begin
      oe_d[pad_d] = 1'b0;
    end
  end

  // Evaluation terms: accumulator update, thresholds, pass bookkeeping
  always_comb begin
    pass_end    = (state == S_EVAL) && (pad == LAST_PAD);
    calibrating = !cal_done_o;
    recal_now   = recal_pend | recal_i;
    pass_inc    = pass_cnt + PC_W'(1);
    cal_finish  = calibrating && pass_end && (pass_inc == PASS_FINAL);
    cnt_ext     = {1'b0, cnt};
    hi_thr      = {1'b0, base[pad]} + CW1'(THRESHOLD);
    lo_thr      = {1'b0, base[pad]} + CW1'(THRESHOLD / 2);
    for (int k = 0; k < N; k++) begin
      acc_upd[k] = (pad == PW'(k)) ? acc[k] + ACC_W'(cnt) : acc[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      pad           <= '0;
      dcnt          <= '0;
      cnt           <= '0;
      sync1         <= '0;
      sync2         <= '0;
      capsense_oe_o <= '1;
      buttons_o     <= '0;
      valid_o       <= 1'b0;
      count_o       <= '0;
      pad_o         <= '0;
      cal_done_o    <= 1'b0;
      busy_o        <= 1'b0;
      pass_cnt      <= '0;
      recal_pend    <= 1'b0;
      for (int k = 0; k < N; k++) begin
        acc[k]  <= '0;
        base[k] <= '0;
      end
    end else begin
      state         <= state_d;
      pad           <= pad_d;
      dcnt          <= dcnt_d;
      cnt           <= cnt_d;
      sync1         <= capsense_i;
      sync2         <= sync1;
      capsense_oe_o <= oe_d;
      busy_o        <= (state_d != S_IDLE);
      valid_o       <= (state == S_EVAL);

      if (state == S_EVAL) begin
        count_o <= cnt;
        pad_o   <= pad;
        if (calibrating) begin
          acc[pad] <= acc_upd[pad];
          if (pass_end) begin
            pass_cnt <= pass_inc;
          end
          if (cal_finish) begin
            for (int k = 0; k < N; k++) begin
              base[k] <= CW'(acc_upd[k] >> CAL_LOG2);
              acc[k]  <= '0;
            end
            cal_done_o <= 1'b1;
            pass_cnt   <= '0;
          end
        end else begin
          if (cnt_ext > hi_thr) begin
            buttons_o[pad] <= 1'b1;
          end else if (cnt_ext < lo_thr) begin
            buttons_o[pad] <= 1'b0;
          end
        end
        // A pending recalibration overrides everything at the pass boundary
        if (pass_end && recal_now) begin
          buttons_o  <= '0;
          cal_done_o <= 1'b0;
          pass_cnt   <= '0;
          for (int k = 0; k < N; k++) begin
            acc[k] <= '0;
          end
        end
      end

      if (pass_end) begin
        recal_pend <= 1'b0;
      end else if (recal_i) begin
        recal_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capsense_scan_ctrl.sv
// Scoreboard bench for capsense_scan_ctrl: a pad model charges each released
// pad after a programmable delay; expected reports are queued and checked on valid_o.
module tb_capsense_scan_ctrl;

  typedef struct {
    int         pad;
    int         cnt;
    logic [3:0] btn;
    logic       cal;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       recal;
  logic [3:0] cs = 4'h0;
  logic [3:0] oe;
  logic [3:0] buttons;
  logic       valid;
  logic [7:0] count;
  logic [1:0] pad;
  logic       cal_done;
  logic       busy;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   npush  = 0;
  int   vcount = 0;
  int   cyc    = 0;
  int   last_cyc = 0;
  int   oe_viol = 0;
  int   oe_one  = 0;
  int   dly [4];
  int   low [4];

  capsense_scan_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .recal_i      (recal),
    .capsense_i   (cs),
    .capsense_oe_o(oe),
    .buttons_o    (buttons),
    .valid_o      (valid),
    .count_o      (count),
    .pad_o        (pad),
    .cal_done_o   (cal_done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: a released pad reads high once it has been released for more than dly cycles
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (oe[p] !== 1'b0) begin
        low[p] = 0;
        cs[p]  = 1'b0;
      end else begin
        low[p] = low[p] + 1;
        cs[p]  = (low[p] > dly[p]);
      end
    end
  end

  // Monitor: pops one expectation per valid_o strobe
  always @(negedge clk) begin
    exp_t e;
    int   gap;
    if (rst_n === 1'b1) begin
      if ($countones(~oe) > 1) oe_viol++;
      if ($countones(~oe) == 1) oe_one++;
    end
    if (valid === 1'b1) begin
      vcount++;
      checks++;
      gap = cyc - last_cyc;
      last_cyc = cyc;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: pad=%0d count=%0d, required no report", pad, count);
      end else begin
        e = q.pop_front();
        if ((int'(count) != e.cnt) || (int'(pad) != e.pad) || (buttons !== e.btn) ||
            (cal_done !== e.cal) || ((e.gap != 0) && (gap != e.gap))) begin
          errors++;
          $display("FAIL report#%0d: pad=%0d count=%0d buttons=%b cal=%b gap=%0d, required pad=%0d count=%0d buttons=%b cal=%b gap=%0d",
                   vcount, pad, count, buttons, cal_done, gap, e.pad, e.cnt, e.btn, e.cal, e.gap);
        end
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int p, input int c, input logic [3:0] b, input logic cal, input bit gap_on);
    exp_t e;
    e.pad = p;
    e.cnt = c;
    e.btn = b;
    e.cal = cal;
    e.gap = gap_on ? c + 18 : 0;
    q.push_back(e);
    npush++;
  endtask

  task automatic wait_valid();
    int n = 0;
    while ((vcount < npush) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    if (vcount < npush) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: reports=%0d, required %0d", vcount, npush);
      finish_run();
    end
  endtask

  task automatic meas(input int p, input int d, input int c, input logic [3:0] b,
                      input logic cal, input bit gap_on);
    dly[p] = d;
    push_exp(p, c, b, cal, gap_on);
    wait_valid();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    recal = 1'b0;
    for (int p = 0; p < 4; p++) begin
      dly[p] = 10;
      low[p] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", int'(oe), 15);
    chk("rst_buttons", int'(buttons), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_cal_done", int'(cal_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_pad", int'(pad), 0);
    rst_n = 1'b1;

    // Start-up calibration: 8 passes of 4 pads, count 12 each, 30-cycle period
    for (int ps = 0; ps < 8; ps++) begin
      for (int p = 0; p < 4; p++) begin
        meas(p, 10, 12, 4'h0, (ps == 7) && (p == 3), !((ps == 0) && (p == 0)));
      end
    end

    // Boundary: count 20 equals baseline+THRESHOLD, so no touch
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 18, 20, 4'h0, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h0, 1'b1, 1'b1);
    // Touch on pad 2
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 25, 27, 4'h4, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h4, 1'b1, 1'b1);
    // Hysteresis band holds at 17 and 16, releases at 15
    meas(0, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(2, 15, 17, 4'h4, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(0, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(2, 14, 16, 4'h4, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(0, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h4, 1'b1, 1'b1);
    meas(2, 13, 15, 4'h0, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h0, 1'b1, 1'b1);

    // Timeout on pad 1 saturates at 255 and counts as a touch
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(1, 1000, 255, 4'h2, 1'b1, 1'b1);
    meas(2, 10, 12, 4'h2, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h2, 1'b1, 1'b1);
    meas(0, 10, 12, 4'h2, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h0, 1'b1, 1'b1);

    // Enable drop during pad 1 charge: pad 1 still reports, then idle
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    dly[1] = 10;
    push_exp(1, 12, 4'h0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_valid();
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_oe", int'(oe), 15);
    repeat (40) @(negedge clk);
    chk("idle_busy_hold", int'(busy), 0);
    en = 1'b1;
    meas(0, 10, 12, 4'h0, 1'b1, 1'b0);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h0, 1'b1, 1'b1);

    // Recalibration requested while pad 2 is touched
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 25, 27, 4'h4, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    recal = 1'b1;
    @(negedge clk);
    recal = 1'b0;
    meas(3, 10, 12, 4'h0, 1'b0, 1'b1);
    dly[2] = 10;
    for (int ps = 0; ps < 8; ps++) begin
      for (int p = 0; p < 4; p++) begin
        meas(p, 10, 12, 4'h0, (ps == 7) && (p == 3), 1'b1);
      end
    end

    // New baseline is exactly 12: 20 does not touch, 21 does
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 18, 20, 4'h0, 1'b1, 1'b1);
    meas(3, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(0, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(1, 10, 12, 4'h0, 1'b1, 1'b1);
    meas(2, 19, 21, 4'h4, 1'b1, 1'b1);

    // Reset during pad 3 charge clears all outputs on the next edge
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_oe", int'(oe), 15);
    chk("midrst_buttons", int'(buttons), 0);
    chk("midrst_cal_done", int'(cal_done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_count", int'(count), 0);

    chk("pending_reports", q.size(), 0);
    chk("oe_multi_release", oe_viol, 0);
    chk("oe_release_seen", int'(oe_one > 0), 1);
    finish_run();
  end

endmodule

// File: doc/capsense_scan_ctrl.md
# capsense_scan_ctrl

Time-multiplexed scan controller for the capacitive-sense pads. It drives the pad output-enable lines one pad at a time (discharge, then release) and times how long each pad takes to charge high through its pull-up. It calibrates a per-pad baseline at start-up and produces debounced, hysteretic touch flags. It sits between the tri-state pad buffers (`oe`/`in` of the pad I/O cells) and the board LEDs/debug pins, and replaces the free-running all-pads-at-once measurement, so pads are measured without mutual crosstalk.

## Interface
- N, 4, number of pads.
- DISCHARGE_CYC, 16, cycles a selected pad is held low before release (>=2).
- TIMEOUT, 255, charge-count saturation value; count width is 8 bits.
- CAL_LOG2, 3, log2 of calibration passes (8 passes).
- THRESHOLD, 8, touch margin above baseline; release margin is THRESHOLD/2.
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- en_i  in  1  scan enable.
- recal_i  in  1  one-cycle request to recalibrate.
- capsense_i  in  N  raw pad levels (asynchronous; 2-FF synchronised inside).
- capsense_oe_o  out  N  1 = pad driven low; 0 = pad released.
- buttons_o  out  N  touch flags.
- valid_o  out  1  one-cycle strobe: new measurement on count_o/pad_o.
- count_o  out  8  last measured charge count.
- pad_o  out  clog2(N)  pad index of count_o.
- cal_done_o  out  1  baselines valid.
- busy_o  out  1  FSM not in IDLE.

## Operation
- Reset values: state IDLE, capsense_oe_o all ones, buttons_o 0, valid_o 0, count_o 0, pad_o 0, cal_done_o 0, busy_o 0, baselines and accumulators 0, pass counter 0.
- Non-selected pads always have oe=1. The selected pad has oe=1 in DISCHARGE and oe=0 in CHARGE/EVAL.
- IDLE: all oe=1. If en_i=1, go to DISCHARGE with pad 0.
- DISCHARGE: exactly DISCHARGE_CYC cycles, then CHARGE with cnt=0.
- CHARGE: each cycle, if sync[pad]=1 or cnt==TIMEOUT, go to EVAL holding cnt; else cnt<=cnt+1. Result: cnt = number of CHARGE cycles with the synchronised input low, saturating at TIMEOUT.
- EVAL (1 cycle):
  - Register count_o=cnt and pad_o=pad. valid_o is high the following cycle.
  - If calibrating: acc[pad] += cnt, with width 8+CAL_LOG2, no overflow possible.
  - Else, compare in 9-bit unsigned arithmetic: set buttons_o[pad] if cnt > base+THRESHOLD; clear if cnt < base+THRESHOLD/2; otherwise hold.
  - Next step: if en_i=0, go to IDLE. Else go to DISCHARGE for pad+1, wrapping N-1 to 0.
- Pass end (EVAL of pad N-1):
  - If calibrating: pass counter increments. When it reaches 2^CAL_LOG2, base[k] = acc[k] >> CAL_LOG2 for all k, cal_done_o<=1, and accumulators clear.
  - If a recal request is latched: buttons_o<=0, cal_done_o<=0, accumulators and pass counter clear, and calibration restarts on the next pass.
- recal_i is latched sticky until the pass end consumes it. recal_i together with a pass end in the same cycle is consumed at that pass end.
- en_i deasserted mid-pad: the current pad completes and reports, then the FSM goes to IDLE. Re-enable restarts at pad 0. Calibration progress is kept, but a partial pass is not counted: the pass counter increments only on pad N-1.
- Reset mid-operation returns every output to its reset value on the next edge.

## Timing
- Per-pad period = DISCHARGE_CYC + (cnt+1) + 1 cycles.
- Synchroniser adds 2 cycles. A pad high from CHARGE cycle k yields cnt = k+2 (saturated).
- valid_o is high the cycle after EVAL, coinciding with the first DISCHARGE cycle of the next pad (or the first IDLE cycle).
- buttons_o and cal_done_o update on the same edge as count_o.
- IDLE→DISCHARGE takes 1 cycle after en_i is sampled high.

## Test plan
Parameters are defaults. The bench pad model drives capsense_i high d cycles after the pad's oe falls.
- Reset: hold rst_ni=0 for 3 cycles with en_i=1 -> capsense_oe_o=4'hF, buttons_o=0, valid_o=0, cal_done_o=0, busy_o=0.
- Calibration: all d=10, en_i=1 -> every count_o=12, per-pad period 30 cycles. cal_done_o rises at the end of pass 8 (32nd valid_o) and baselines are 12. Check that exactly one oe bit is 0 at any time.
- Touch hysteresis on pad 2 after calibration:
  - d=25 gives count 27 -> buttons_o=4'b0100.
  - d=15 gives count 17 -> flag stays set.
  - d=13 gives count 15 -> buttons_o=0.
  - Other pads at d=10 stay 0.
- Timeout: pad 1 never rises -> count_o=255, pad_o=1, buttons_o[1]=1, next valid_o reports pad_o=2.
- Enable drop: deassert en_i during pad 1 CHARGE -> pad 1 valid_o still occurs, then busy_o=0 and oe=4'hF. Reassert -> next valid_o has pad_o=0.
- Recalibration: pulse recal_i while pad 2 is touched -> at the end of the current pass buttons_o=0 and cal_done_o=0. After 8 more passes at d=10, cal_done_o=1 and baselines are 12.
